// File: rtl/config_reg_pkg.sv
// Shared definitions for the config_reg bring-up sequencer: register map,
// reset-value table, sequence modes, FSM states and the write-data rule.
package config_reg_pkg;

  localparam int NUM_REGS = 8;

  // Register map of the 8 x 16-bit config_reg file, in address order.
  typedef enum logic [2:0] {
    ADC0_REG         = 3'd0,
    ADC1_REG         = 3'd1,
    TEMP_SENSOR0_REG = 3'd2,
    TEMP_SENSOR1_REG = 3'd3,
    ANALOG_TEST      = 3'd4,
    DIGITAL_TEST     = 3'd5,
    AMP_GAIN         = 3'd6,
    DIGITAL_CONFIG   = 3'd7
  } reg_t;

  // Power-on contents of config_reg, indexed by address.
  localparam logic [15:0] RESET_VALS [NUM_REGS] = '{
    16'hFFFF,  // ADC0_REG
    16'h0000,  // ADC1_REG
    16'h0000,  // TEMP_SENSOR0_REG
    16'h0000,  // TEMP_SENSOR1_REG
    16'hABCD,  // ANALOG_TEST
    16'h0000,  // DIGITAL_TEST
    16'h0000,  // AMP_GAIN
    16'h0001   // DIGITAL_CONFIG
  };

  // Address of the last register; finishing it ends the sequence.
  localparam logic [2:0] LAST_ADDR = 3'(NUM_REGS - 1);

  // Sequence selected by the mode input on an accepted start.
  typedef enum logic [1:0] {
    CHK_RESET = 2'd0,
    WR_VERIFY = 2'd1,
    WALK1     = 2'd2,
    RSVD      = 2'd3
  } seq_mode_t;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_FIN  = 2'd3
  } seq_state_t;

  // Value written for (addr, bit): the table entry for write-verify, a single
  // set bit for walking-ones. Not used by the reset-check sequence.
  function automatic logic [15:0] seq_wdata(input seq_mode_t     m,
                                            input logic [127:0]  tbl,
                                            input logic [2:0]    a,
                                            input logic [3:0]    b);
    logic [15:0] w;
    if (m == WALK1) w = 16'h0001 << b;
    else            w = tbl[{a, 4'b0000} +: 16];
    return w;
  endfunction

endpackage

// File: rtl/config_reg_seq_stats.sv
// Compare statistics: saturating pass/error counters and first-mismatch capture.
module config_reg_seq_stats
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             cmp_valid,
  input  logic             match,
  input  logic [2:0]       addr,
  input  logic [15:0]      exp_val,
  input  logic [15:0]      act_val,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_addr,
  output logic [15:0]      fail_exp,
  output logic [15:0]      fail_act
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count each compare, saturating at all-ones, and freeze the first mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_count <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
    end else if (clear) begin
      pass_count <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
    end else if (cmp_valid) begin
      if (match) begin
        if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
      end else begin
        if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_addr  <= addr;
          fail_exp   <= exp_val;
          fail_act   <= act_val;
        end
      end
    end
  end

endmodule

// File: rtl/config_reg_seq.sv
// Hardware initiator for config_reg: walks all eight registers and runs a
// reset-value check, a table write/readback or a walking-ones write/readback.
//
// Handshake: start is a one-cycle request accepted only while idle (busy=0,
// done=0 or the done cycle itself); mode and wr_tbl are sampled on that same
// edge. done is a one-cycle pulse; results hold until the next accepted start.
// Towards config_reg, cr_write is a one-cycle strobe with cr_address and
// cr_data_in valid in that cycle; reads present cr_address with cr_write low
// and sample cr_data_out RD_LAT cycles later.
module config_reg_seq
  import config_reg_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [127:0]     wr_tbl,
  output logic             cr_write,
  output logic [2:0]       cr_address,
  output logic [15:0]      cr_data_in,
  input  logic [15:0]      cr_data_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_addr,
  output logic [15:0]      fail_exp,
  output logic [15:0]      fail_act,
  output logic [1:0]       fsm_state
);

  // Final RD cycle index; the readback is sampled on the edge that ends it.
  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

  seq_state_t   state;
  seq_mode_t    mode_q;
  logic [127:0] tbl_q;
  logic [2:0]   addr;
  logic [3:0]   bit_idx;
  logic [1:0]   rd_cnt;

  logic         clear;
  logic         cmp_valid;
  logic         match;
  logic [15:0]  exp_val;
  logic [2:0]   addr_nx;

  assign fsm_state = state;
  assign addr_nx   = addr + 3'd1;

  // Compare strobe and expected readback for the register being checked.
  // In the write sequences cr_data_in still holds the value just written.
  always_comb begin
    clear     = 1'b0;
    cmp_valid = 1'b0;
    exp_val   = cr_data_in;
    if (state == ST_IDLE && start)                clear     = 1'b1;
    if (state == ST_RD && rd_cnt == RD_LAST)      cmp_valid = 1'b1;
    if (mode_q == CHK_RESET)                      exp_val   = RESET_VALS[addr];
    match = (cr_data_out == exp_val);
  end

  // Sequencer FSM; all bus and status outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      mode_q     <= CHK_RESET;
      tbl_q      <= '0;
      addr       <= '0;
      bit_idx    <= '0;
      rd_cnt     <= '0;
      cr_write   <= 1'b0;
      cr_address <= '0;
      cr_data_in <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q     <= seq_mode_t'(mode);
            tbl_q      <= wr_tbl;
            addr       <= '0;
            bit_idx    <= '0;
            rd_cnt     <= '0;
            busy       <= 1'b1;
            cr_address <= '0;
            case (seq_mode_t'(mode))
              CHK_RESET: begin
                cr_write <= 1'b0;
                state    <= ST_RD;
              end
              WR_VERIFY, WALK1: begin
                cr_write   <= 1'b1;
                cr_data_in <= seq_wdata(seq_mode_t'(mode), wr_tbl, 3'd0, 4'd0);
                state      <= ST_WR;
              end
              default: begin
                cr_write <= 1'b0;
                state    <= ST_FIN;
              end
            endcase
          end
        end

        ST_WR: begin
          cr_write <= 1'b0;
          rd_cnt   <= '0;
          state    <= ST_RD;
        end

        ST_RD: begin
          if (rd_cnt != RD_LAST) begin
            rd_cnt <= rd_cnt + 2'd1;
          end else begin
            rd_cnt <= '0;
            if (mode_q == WALK1 && bit_idx != 4'd15) begin
              // Next bit of the same register.
              bit_idx    <= bit_idx + 4'd1;
              cr_write   <= 1'b1;
              cr_data_in <= seq_wdata(mode_q, tbl_q, addr, bit_idx + 4'd1);
              state      <= ST_WR;
            end else begin
              // Register finished; addr wraps to 0 after the last one.
              bit_idx <= '0;
              addr    <= addr_nx;
              if (addr == LAST_ADDR) begin
                state <= ST_FIN;
              end else begin
                cr_address <= addr_nx;
                if (mode_q == CHK_RESET) begin
                  state <= ST_RD;
                end else begin
                  cr_write   <= 1'b1;
                  cr_data_in <= seq_wdata(mode_q, tbl_q, addr_nx, 4'd0);
                  state      <= ST_WR;
                end
              end
            end
          end
        end

        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  config_reg_seq_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .cmp_valid  (cmp_valid),
    .match      (match),
    .addr       (addr),
    .exp_val    (exp_val),
    .act_val    (cr_data_out),
    .pass_count (pass_count),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_addr  (fail_addr),
    .fail_exp   (fail_exp),
    .fail_act   (fail_act)
  );

endmodule
